// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: req/ack word reads into a prefetch FIFO,
// valid/ready delivery to decode, redirect flushes and refetches.
module instruction_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];

  logic          ack;
  logic          push;
  logic          pop;
  logic [CW-1:0] proj;
  logic [31:0]   target;
  logic [31:0]   next_pc;

  // FIFO bookkeeping; redirect cancels push/pop and empties the buffer
  always_comb begin
    ack    = mem_req_q && mem_ack;
    target = redirect_pc & 32'hFFFF_FFFC;
    push   = (state_q == REQ) && ack && !redirect;
    pop    = (count_q != '0) && inst_ready && !redirect;
    proj   = count_q + CW'(push) - CW'(pop);
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (push) begin
      inst_mem_d[wptr_q] = mem_rdata;
      pc_mem_d[wptr_q]   = mem_addr_q;
    end
    if (redirect) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      count_d = proj;
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    end
  end

  // Request FSM: one outstanding read, issued only with a free slot
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    next_pc    = fetch_pc_q + 32'd4;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d    = REQ;
          mem_addr_d = target;
          fetch_pc_d = target;
        end else if (proj < CW'(DEPTH)) begin
          state_d    = REQ;
          mem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = target;
          if (ack) begin
            mem_addr_d = target;
          end else begin
            state_d = DROP;
          end
        end else if (ack) begin
          fetch_pc_d = next_pc;
          if (proj < CW'(DEPTH)) begin
            mem_addr_d = next_pc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_d = target;
        end
        if (ack) begin
          state_d    = REQ;
          mem_addr_d = redirect ? target : fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d != IDLE);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem_q[rptr_q];
  assign inst_pc    = pc_mem_q[rptr_q];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-configurable
// memory responder and an in-order scoreboard of delivered words.
module tb_instruction_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  exp_t sbq[$];
  int   tests   = 0;
  int   fails   = 0;
  int   lat     = 0;
  int   wcnt    = 0;
  int   ack_cnt = 0;
  bit   discard = 0;

  instruction_fetch_unit #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    mem_ack   = mem_req && (wcnt >= lat);
    mem_rdata = mem_addr ^ K;
  endtask

  task automatic tick();
    logic ev_ack;
    logic ev_pop;
    logic req_b4;
    exp_t e;
    ev_ack = mem_req && mem_ack;
    ev_pop = inst_valid && inst_ready;
    req_b4 = mem_req;
    if (rst) begin
      sbq.delete();
      discard = 0;
      ack_cnt = 0;
    end else if (redirect) begin
      sbq.delete();
      discard = mem_req && !mem_ack;
      if (ev_ack) ack_cnt++;
    end else begin
      if (ev_pop) begin
        chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_inst_pc", inst_pc, e.pc);
          chk("sb_inst", inst, e.ins);
        end
      end
      if (ev_ack) begin
        ack_cnt++;
        if (discard) begin
          discard = 0;
        end else begin
          e.pc  = mem_addr;
          e.ins = mem_rdata;
          sbq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    if (rst || ev_ack || !req_b4) wcnt = 0;
    else wcnt++;
    drive_mem();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    inst_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    lat = 0;

    // reset state and first request
    tick();
    chk_reset_outputs("rst0");
    rst = 1'b0;
    tick();
    chk("req_rise", 32'(mem_req), 32'd1);
    chk("req_addr0", mem_addr, 32'h0);
    tick();
    // zero-wait streaming, one word per cycle
    for (int k = 0; k < 8; k++) begin
      chk("stream_valid", 32'(inst_valid), 32'd1);
      chk("stream_pc", inst_pc, 32'(k * 4));
      chk("stream_inst", inst, 32'(k * 4) ^ K);
      tick();
    end

    // stalled decode: exactly DEPTH fetches, then one per pop
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst_ready = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("full_acks", 32'(ack_cnt), 32'd4);
    chk("full_req_low", 32'(mem_req), 32'd0);
    chk("full_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("pop_req", 32'(mem_req), 32'd1);
    chk("pop_addr", mem_addr, 32'd16);
    chk("pop_head_pc", inst_pc, 32'd4);
    for (int k = 0; k < 10; k++) tick();
    chk("pop_acks", 32'(ack_cnt), 32'd5);
    chk("pop_req_low", 32'(mem_req), 32'd0);

    // redirect during a slow in-flight read
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat = 3;
    inst_ready = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    chk("drop_valid", 32'(inst_valid), 32'd0);
    chk("drop_req", 32'(mem_req), 32'd1);
    chk("drop_addr_held", mem_addr, 32'h0);
    for (int k = 0; k < 20 && mem_addr != 32'h100; k++) tick();
    chk("drop_next_addr", mem_addr, 32'h100);
    for (int k = 0; k < 20 && !inst_valid; k++) tick();
    chk("drop_first_valid", 32'(inst_valid), 32'd1);
    chk("drop_first_pc", inst_pc, 32'h100);
    chk("drop_first_inst", inst, 32'h100 ^ K);

    // redirect coinciding with ack and pop, two entries buffered
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat = 0;
    inst_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("two_valid", 32'(inst_valid), 32'd1);
    chk("two_head", inst_pc, 32'h0);
    chk("two_ack", 32'(mem_ack), 32'd1);
    inst_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_req", 32'(mem_req), 32'd1);
    chk("flush_addr", mem_addr, 32'h200);
    tick();
    chk("flush_first_pc", inst_pc, 32'h200);

    // fetch address wrap at 2^32
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc1", inst_pc, 32'h0);
    chk("wrap_inst1", inst, K);

    // reset with three buffered entries and a read in flight
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    lat = 3;
    drive_mem();
    tick();
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst_busy");
    rst = 1'b0;
    lat = 0;
    tick();
    chk("restart_req", 32'(mem_req), 32'd1);
    chk("restart_addr", mem_addr, 32'h0);

    // reset while discarding an in-flight read
    lat = 3;
    drive_mem();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    chk("drop2_addr_held", mem_addr, 32'h0);
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst_drop");
    rst = 1'b0;
    lat = 0;
    inst_ready = 1'b1;
    tick();
    chk("restart2_addr", mem_addr, 32'h0);
    tick();
    chk("restart2_pc", inst_pc, 32'h0);
    tick();
    chk("restart2_pc1", inst_pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
